// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared Game of Life constants, engine state codes and scheduler state enum
package gol_pkg;
  localparam logic [3:0] ENG_S_INIT = 4'd0;
  localparam logic [3:0] ENG_S_IDLE = 4'd5;
  localparam int GRID_BITS = 8;
  localparam int SPECIES_W = 5;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_EDIT
  } sched_state_e;
endpackage

// File: rtl/gol_ram_port_mux.sv
// rtl/gol_ram_port_mux.sv - cell RAM port select: engine pass-through or one edit write into the displayed bank
module gol_ram_port_mux
  import gol_pkg::*;
(
  input  logic                   sel_edit,
  input  logic                   bank_sel,
  input  logic [2*GRID_BITS-1:0] eng_addr,
  input  logic                   eng_we0,
  input  logic                   eng_we1,
  input  logic [SPECIES_W-1:0]   eng_din,
  input  logic [2*GRID_BITS-1:0] edit_addr,
  input  logic [SPECIES_W-1:0]   edit_din,
  output logic [2*GRID_BITS-1:0] ram_addr,
  output logic                   ram_we0,
  output logic                   ram_we1,
  output logic [SPECIES_W-1:0]   ram_din
);
  always_comb begin
    ram_addr = eng_addr;
    ram_we0  = eng_we0;
    ram_we1  = eng_we1;
    ram_din  = eng_din;
    if (sel_edit) begin
      // edits land in the bank currently on screen
      ram_addr = edit_addr;
      ram_din  = edit_din;
      ram_we0  = ~bank_sel;
      ram_we1  = bank_sel;
    end
  end
endmodule

// File: rtl/gol_sched.sv
// rtl/gol_sched.sv - generation scheduler and cell-RAM port owner for the GoL engine
// GOL_SCHED_OVERRUN_EN: when defined, keeps a saturating count of frame ticks lost while the engine is busy
module gol_sched
  import gol_pkg::*;
#(
  parameter int SPEED_W = 4,
  parameter int GEN_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   video_sof,
  input  logic                   run,
  input  logic                   step_req,
  input  logic [SPEED_W-1:0]     speed,
  input  logic [GEN_W-1:0]       gen_limit,
  input  logic [3:0]             eng_state,
  input  logic                   eng_init_done,
  input  logic                   eng_ram_select,
  input  logic [2*GRID_BITS-1:0] eng_addr,
  input  logic                   eng_we0,
  input  logic                   eng_we1,
  input  logic [SPECIES_W-1:0]   eng_din,
  output logic                   eng_sof,
  input  logic                   edit_valid,
  output logic                   edit_ready,
  input  logic [GRID_BITS-1:0]   edit_x,
  input  logic [GRID_BITS-1:0]   edit_y,
  input  logic [SPECIES_W-1:0]   edit_species,
  output logic [2*GRID_BITS-1:0] ram_addr,
  output logic                   ram_we0,
  output logic                   ram_we1,
  output logic [SPECIES_W-1:0]   ram_din,
  output logic                   paused,
  output logic [GEN_W-1:0]       gens_issued,
  output logic [15:0]            overrun_count
);
  sched_state_e           state_q, state_d;
  logic [SPEED_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                   issue_pend_q, issue_pend_d;
  logic                   seen_run_q, seen_run_d;
  logic [GEN_W-1:0]       gens_issued_q, gens_issued_d;
  logic [GEN_W-1:0]       gen_limit_q, gen_limit_d;
  logic [2*GRID_BITS-1:0] edit_addr_q, edit_addr_d;
  logic [SPECIES_W-1:0]   edit_din_q, edit_din_d;
  logic                   limit_reached, in_init, frame_tick, frame_wrap, step_ok;
`ifdef GOL_SCHED_OVERRUN_EN
  logic [15:0]            overrun_q, overrun_d;
`endif

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    issue_pend_d  = issue_pend_q;
    seen_run_d    = seen_run_q;
    gens_issued_d = gens_issued_q;
    gen_limit_d   = gen_limit;
    edit_addr_d   = edit_addr_q;
    edit_din_d    = edit_din_q;

    limit_reached = (gen_limit != '0) && (gens_issued_q >= gen_limit);
    in_init       = (state_q == S_WAIT_INIT);
    frame_tick    = video_sof && run && !limit_reached && !in_init;
    // >= rather than == so a speed lowered below the running count still wraps at once
    frame_wrap    = frame_tick && (frame_cnt_q >= speed);
    step_ok       = step_req && !in_init && !limit_reached;

    if (frame_wrap)      frame_cnt_d = '0;
    else if (frame_tick) frame_cnt_d = frame_cnt_q + 1'b1;

    if (state_q == S_ISSUE)     issue_pend_d = 1'b0;
    if (frame_wrap || step_ok)  issue_pend_d = 1'b1;

    if (gen_limit != gen_limit_q)
      gens_issued_d = '0;
    else if (state_q == S_ISSUE && gens_issued_q != '1)
      gens_issued_d = gens_issued_q + 1'b1;

    edit_ready = (state_q == S_IDLE) && (eng_state == ENG_S_IDLE) && !rst;
    eng_sof    = (state_q == S_ISSUE) && !rst;
    paused     = rst || !run || limit_reached || in_init;

    case (state_q)
      S_WAIT_INIT: if (eng_init_done && eng_state == ENG_S_IDLE) state_d = S_IDLE;
      S_IDLE: begin
        if (edit_valid && edit_ready) begin
          edit_addr_d = {edit_y, edit_x};
          edit_din_d  = edit_species;
          state_d     = S_EDIT;
        end else if (issue_pend_q) begin
          state_d = S_ISSUE;
        end
      end
      // a request that arrived alongside the edit is issued straight away
      S_EDIT:  state_d = issue_pend_q ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        seen_run_d = 1'b0;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        if (eng_state != ENG_S_IDLE) seen_run_d = 1'b1;
        if (seen_run_q && eng_state == ENG_S_IDLE) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase

`ifdef GOL_SCHED_OVERRUN_EN
    overrun_d = overrun_q;
    if (state_q == S_BUSY && frame_wrap && issue_pend_q && overrun_q != '1)
      overrun_d = overrun_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_WAIT_INIT;
      frame_cnt_q   <= '0;
      issue_pend_q  <= 1'b0;
      seen_run_q    <= 1'b0;
      gens_issued_q <= '0;
      gen_limit_q   <= '0;
      edit_addr_q   <= '0;
      edit_din_q    <= '0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      issue_pend_q  <= issue_pend_d;
      seen_run_q    <= seen_run_d;
      gens_issued_q <= gens_issued_d;
      gen_limit_q   <= gen_limit_d;
      edit_addr_q   <= edit_addr_d;
      edit_din_q    <= edit_din_d;
    end
  end

`ifdef GOL_SCHED_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) overrun_q <= '0;
    else     overrun_q <= overrun_d;
  end
  assign overrun_count = overrun_q;
`else
  assign overrun_count = '0;
`endif

  assign gens_issued = gens_issued_q;

  gol_ram_port_mux u_mux (
    .sel_edit  ((state_q == S_EDIT) && !rst),
    .bank_sel  (eng_ram_select),
    .eng_addr  (eng_addr),
    .eng_we0   (eng_we0),
    .eng_we1   (eng_we1),
    .eng_din   (eng_din),
    .edit_addr (edit_addr_q),
    .edit_din  (edit_din_q),
    .ram_addr  (ram_addr),
    .ram_we0   (ram_we0),
    .ram_we1   (ram_we1),
    .ram_din   (ram_din)
  );
endmodule
